// File: rtl/cic_comp_fir.sv
// cic_comp_fir: symmetric odd-length CIC droop-compensation FIR.
// One shared pre-add/MAC walks the NU unique coefficients per input sample,
// then a round/saturate step produces the output. Coefficients are writable
// while idle and come out of reset as a pure delay (centre tap = 1.0).
module cic_comp_fir #(
    parameter int DATA_WIDTH = 16,
    parameter int COEF_WIDTH = 16,
    parameter int COEF_FRAC  = 14,
    parameter int TAPS       = 15,
    localparam int NU        = (TAPS + 1) / 2,
    localparam int AW        = $clog2(NU)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] x_in,
    input  logic                  x_valid,
    input  logic                  coef_we,
    input  logic [AW-1:0]         coef_addr,
    input  logic [COEF_WIDTH-1:0] coef_data,
    output logic [DATA_WIDTH-1:0] y_out,
    output logic                  y_valid,
    output logic                  busy,
    output logic                  overrun
);

    localparam int PW   = DATA_WIDTH + 1;           // pre-add width
    localparam int PRW  = PW + COEF_WIDTH;          // product width
    localparam int ACCW = PRW + $clog2(NU);         // accumulator width
    localparam int DIW  = $clog2(TAPS);             // delay-line index width

    localparam logic [AW-1:0]           LASTC = AW'(NU - 1);
    localparam logic signed [ACCW-1:0]  HALF  = ACCW'(2 ** (COEF_FRAC - 1));
    localparam logic signed [ACCW-1:0]  SMAX  = ACCW'((2 ** (DATA_WIDTH - 1)) - 1);
    localparam logic signed [ACCW-1:0]  SMIN  = ~SMAX;
    localparam logic [DATA_WIDTH-1:0]   YMAX  = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0]   YMIN  = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [COEF_WIDTH-1:0]   ONE   = COEF_WIDTH'(2 ** COEF_FRAC);

    typedef enum logic [1:0] {IDLE, MAC, ROUND} state_t;

    state_t                        state_q;
    logic [AW-1:0]                 cnt_q;
    logic signed [ACCW-1:0]        acc_q;
    logic signed [DATA_WIDTH-1:0]  d_q    [TAPS];
    logic signed [COEF_WIDTH-1:0]  coef_q [NU];
    logic [DATA_WIDTH-1:0]         y_q;
    logic                          y_valid_q;
    logic                          overrun_q;

    logic [DIW-1:0]                near_idx;
    logic [DIW-1:0]                far_idx;
    logic signed [PW-1:0]          pre;
    logic signed [PRW-1:0]         prod;
    logic signed [ACCW-1:0]        acc_d;
    logic signed [ACCW-1:0]        rnd;
    logic signed [ACCW-1:0]        shifted;
    logic [DATA_WIDTH-1:0]         y_d;

    // Pre-add the mirrored tap pair for the current coefficient; centre tap stands alone.
    always_comb begin
        near_idx = DIW'(cnt_q);
        far_idx  = DIW'(TAPS - 1) - DIW'(cnt_q);
        pre      = PW'(d_q[near_idx]);
        if (cnt_q != LASTC)
            pre = PW'(d_q[near_idx]) + PW'(d_q[far_idx]);
        prod  = PRW'(pre) * PRW'(coef_q[cnt_q]);
        acc_d = acc_q + ACCW'(prod);
    end

    // Round half-up, drop the fraction bits, then clamp to the output range.
    always_comb begin
        rnd     = acc_q + HALF;
        shifted = rnd >>> COEF_FRAC;
        if (shifted > SMAX)
            y_d = YMAX;
        else if (shifted < SMIN)
            y_d = YMIN;
        else
            y_d = shifted[DATA_WIDTH-1:0];
    end

    // Control FSM plus delay line, coefficient store and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            y_q       <= '0;
            y_valid_q <= 1'b0;
            overrun_q <= 1'b0;
            for (int i = 0; i < TAPS; i++) d_q[i] <= '0;
            for (int i = 0; i < NU; i++)
                coef_q[i] <= (i == NU - 1) ? ONE : '0;
        end else begin
            y_valid_q <= 1'b0;
            // A sample arriving mid-computation is lost; flag it permanently.
            if (x_valid && state_q != IDLE) overrun_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (coef_we && int'(coef_addr) < NU)
                        coef_q[coef_addr] <= coef_data;
                    if (x_valid) begin
                        d_q[0] <= x_in;
                        for (int i = 1; i < TAPS; i++) d_q[i] <= d_q[i-1];
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= MAC;
                    end
                end
                MAC: begin
                    acc_q <= acc_d;
                    if (cnt_q == LASTC)
                        state_q <= ROUND;
                    else
                        cnt_q <= cnt_q + 1'b1;
                end
                ROUND: begin
                    y_q       <= y_d;
                    y_valid_q <= 1'b1;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign y_out   = y_q;
    assign y_valid = y_valid_q;
    assign overrun = overrun_q;
    assign busy    = (state_q != IDLE);

endmodule
